// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage ALU: registered result/flags with back-pressure, saturating ADD/SUB,
// XOR, per-lane saturating PADDSB and a two-cycle pipelined byte-lane reduction (RED).
module alu_exec_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NIB   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             out_err,
   output logic             flag_z,
   output logic             flag_v,
   output logic             flag_n
);

   localparam int unsigned NLANE = WIDTH / 8;
   localparam int unsigned NPLANE = WIDTH / NIB;

   localparam logic [2:0] OpAdd    = 3'b000;
   localparam logic [2:0] OpSub    = 3'b001;
   localparam logic [2:0] OpXor    = 3'b010;
   localparam logic [2:0] OpRed    = 3'b011;
   localparam logic [2:0] OpPaddsb = 3'b100;

   localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH - 1){1'b1}}};
   localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH - 1){1'b0}}};
   localparam logic [NIB-1:0]   LaneMax = {1'b0, {(NIB - 1){1'b1}}};
   localparam logic [NIB-1:0]   LaneMin = {1'b1, {(NIB - 1){1'b0}}};

   typedef enum logic [0:0] {StIdle, StRed2} state_e;

   state_e                 state_q, state_d;
   logic                   out_valid_q, out_valid_d;
   logic [WIDTH-1:0]       result_q, result_d;
   logic                   err_q, err_d;
   logic                   z_q, z_d;
   logic                   v_q, v_d;
   logic                   n_q, n_d;
   logic [9*NLANE-1:0]     lane_q, lane_d;

   logic                   accept;
   logic [WIDTH:0]         a_x, b_x, addsub_x;
   logic                   addsub_ovf;
   logic [WIDTH-1:0]       addsub_sat;
   logic [WIDTH-1:0]       xor_res;
   logic [WIDTH-1:0]       paddsb_res;
   logic [9*NLANE-1:0]     lane_s1;
   logic [WIDTH-1:0]       red_sum;

   assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // One guard bit above the sign catches signed overflow for both ADD and SUB.
   assign a_x        = {a[WIDTH-1], a};
   assign b_x        = {b[WIDTH-1], b};
   assign addsub_x   = (op == OpSub) ? (a_x + (~b_x + 1'b1)) : (a_x + b_x);
   assign addsub_ovf = addsub_x[WIDTH] ^ addsub_x[WIDTH-1];
   assign addsub_sat = !addsub_ovf      ? addsub_x[WIDTH-1:0] :
                       addsub_x[WIDTH]  ? SatMin : SatMax;

   assign xor_res = a ^ b;

   always_comb begin
      paddsb_res = '0;
      for (int unsigned i = 0; i < NPLANE; i++) begin
         logic [NIB:0] lsum;
         lsum = {a[i*NIB+NIB-1], a[i*NIB +: NIB]} + {b[i*NIB+NIB-1], b[i*NIB +: NIB]};
         if (lsum[NIB] ^ lsum[NIB-1]) begin
            paddsb_res[i*NIB +: NIB] = lsum[NIB] ? LaneMin : LaneMax;
         end else begin
            paddsb_res[i*NIB +: NIB] = lsum[NIB-1:0];
         end
      end
   end

   // Stage 1: 9-bit signed sum per byte lane, registered into lane_q.
   always_comb begin
      lane_s1 = '0;
      for (int unsigned i = 0; i < NLANE; i++) begin
         lane_s1[9*i +: 9] = {a[8*i+7], a[8*i +: 8]} + {b[8*i+7], b[8*i +: 8]};
      end
   end

   // Stage 2: WIDTH >= 16 always holds the full-precision lane total.
   always_comb begin
      red_sum = '0;
      for (int unsigned i = 0; i < NLANE; i++) begin
         red_sum = red_sum + {{(WIDTH - 9){lane_q[9*i+8]}}, lane_q[9*i +: 9]};
      end
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q & ~out_ready;
      result_d    = result_q;
      err_d       = err_q;
      z_d         = z_q;
      v_d         = v_q;
      n_d         = n_q;
      lane_d      = lane_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               out_valid_d = 1'b1;
               case (op)
                  OpAdd, OpSub: begin
                     result_d = addsub_sat;
                     err_d    = 1'b0;
                     z_d      = (addsub_sat == '0);
                     v_d      = addsub_ovf;
                     n_d      = addsub_sat[WIDTH-1];
                  end
                  OpXor: begin
                     result_d = xor_res;
                     err_d    = 1'b0;
                     z_d      = (xor_res == '0);
                  end
                  OpRed: begin
                     // Output register is free here: acceptance implied it was empty or draining.
                     out_valid_d = 1'b0;
                     lane_d      = lane_s1;
                     state_d     = StRed2;
                  end
                  OpPaddsb: begin
                     result_d = paddsb_res;
                     err_d    = 1'b0;
                  end
                  default: begin
                     result_d = '0;
                     err_d    = 1'b1;
                  end
               endcase
            end
         end
         StRed2: begin
            result_d    = red_sum;
            err_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         err_q       <= 1'b0;
         z_q         <= 1'b0;
         v_q         <= 1'b0;
         n_q         <= 1'b0;
         lane_q      <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         err_q       <= err_d;
         z_q         <= z_d;
         v_q         <= v_d;
         n_q         <= n_d;
         lane_q      <= lane_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign out_err   = err_q;
   assign flag_z    = z_q;
   assign flag_v    = v_q;
   assign flag_n    = n_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: 16-bit instance checked against a behavioural model,
// plus a 32-bit instance for width scaling of RED and reset during RED2.
module tb_alu_exec_unit;

   localparam int W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [2:0]    op;
   logic [W-1:0]  a, b, result;
   logic          out_err, flag_z, flag_v, flag_n;

   logic          in_valid32, in_ready32, out_valid32;
   logic [2:0]    op32;
   logic [31:0]   a32, b32, result32;
   logic          out_err32, flag_z32, flag_v32, flag_n32;

   alu_exec_unit #(.WIDTH(16), .NIB(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_err(out_err),
      .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
   );

   alu_exec_unit #(.WIDTH(32), .NIB(4)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .op(op32),
      .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(1'b1), .result(result32),
      .out_err(out_err32), .flag_z(flag_z32), .flag_v(flag_v32), .flag_n(flag_n32)
   );

   typedef struct packed {
      logic [W-1:0] res;
      logic         err;
      logic         z;
      logic         v;
      logic         n;
   } exp_t;

   exp_t sb[$];
   exp_t got_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic mz = 1'b0, mv = 1'b0, mn = 1'b0;
   logic rand_phase;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model; also tracks the architectural flags.
   task automatic push_exp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t             e;
      longint           s, maxv, minv;
      logic signed [7:0] ba, bb;
      logic signed [3:0] na, nb;
      int               t;
      logic [W-1:0]     r;
      maxv = (longint'(1) << (W - 1)) - 1;
      minv = -maxv - 1;
      e.res = '0; e.err = 1'b0; e.z = mz; e.v = mv; e.n = mn;
      case (o)
         3'd0, 3'd1: begin
            s = (o == 3'd0) ? longint'($signed(x)) + longint'($signed(y))
                            : longint'($signed(x)) - longint'($signed(y));
            e.v = (s > maxv) || (s < minv);
            if (s > maxv) s = maxv;
            if (s < minv) s = minv;
            e.res = s[W-1:0];
            e.z = (e.res == '0);
            e.n = e.res[W-1];
         end
         3'd2: begin
            e.res = x ^ y;
            e.z = (e.res == '0);
         end
         3'd3: begin
            s = 0;
            for (int i = 0; i < W / 8; i++) begin
               ba = x[8*i +: 8];
               bb = y[8*i +: 8];
               s = s + longint'(ba) + longint'(bb);
            end
            e.res = s[W-1:0];
         end
         3'd4: begin
            r = '0;
            for (int i = 0; i < W / 4; i++) begin
               na = x[4*i +: 4];
               nb = y[4*i +: 4];
               t = int'(na) + int'(nb);
               if (t > 7) t = 7;
               if (t < -8) t = -8;
               r[4*i +: 4] = t[3:0];
            end
            e.res = r;
         end
         default: e.err = 1'b1;
      endcase
      mz = e.z; mv = e.v; mn = e.n;
      sb.push_back(e);
   endtask

   // Drive one request and hold it until accepted; returns #1 after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int   cnt;
      logic acc;
      cnt = 0;
      op = o; a = x; b = y; in_valid = 1'b1;
      push_exp(o, x, y);
      forever begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         cnt++;
         if (cnt >= 50) begin
            check("accept_timeout", 32'(acc), 32'd1);
            void'(sb.pop_back());
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            got_e = sb.pop_front();
            check("result", 32'(result), 32'(got_e.res));
            check("out_err", 32'(out_err), 32'(got_e.err));
            check("flag_z", 32'(flag_z), 32'(got_e.z));
            check("flag_v", 32'(flag_v), 32'(got_e.v));
            check("flag_n", 32'(flag_n), 32'(got_e.n));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
      in_valid32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; rand_phase = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'({out_err, flag_z, flag_v, flag_n}), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      issue(3'd0, 16'h7FF0, 16'h0020);
      check("add_lat1_valid", 32'(out_valid), 32'd1);
      check("add_pos_sat", 32'(result), 32'h7FFF);
      check("add_v", 32'(flag_v), 32'd1);
      issue(3'd1, 16'h8000, 16'h0001);
      issue(3'd0, 16'h8000, 16'hFFFF);
      issue(3'd1, 16'h0005, 16'h0005);
      check("sub_zero", 32'({flag_z, flag_v, flag_n}), 32'b100);
      issue(3'd2, 16'h00FF, 16'h0F0F);
      check("xor_res", 32'(result), 32'h0FF0);

      issue(3'd3, 16'h0102, 16'h0304);
      check("red2_in_ready", 32'(in_ready), 32'd0);
      check("red2_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("red_lat2", 32'({out_valid, result}), 32'h1000A);
      issue(3'd3, 16'h8080, 16'h8080);
      @(posedge clk); #1;
      check("red_neg", 32'(result), 32'hFE00);
      issue(3'd4, 16'h7788, 16'h1111);
      check("paddsb", 32'(result), 32'h7799);
      issue(3'd7, 16'h1234, 16'h5678);
      check("illegal", 32'({out_err, result}), 32'h10000);

      // Back-pressure: drain, then stall a result and queue a second request behind it.
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(3'd0, 16'h0001, 16'h0002);
      op = 3'd2; a = 16'h0005; b = 16'h0003; in_valid = 1'b1;
      push_exp(3'd2, 16'h0005, 16'h0003);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_hold", 32'({in_ready, out_valid, result}), 32'h10003);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_next", 32'({out_valid, result}), 32'h10006);

      // Random phase with random back-pressure.
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
            end
            rand_phase = 1'b0;
         end
         begin
            while (rand_phase) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check("drain", 32'(sb.size()), 32'd0);

      // Reset while RED is in RED2; force nonzero flags first.
      issue(3'd1, 16'h8000, 16'h0001);
      issue(3'd3, 16'h0102, 16'h0304);
      rst = 1'b1;
      sb.delete();
      mz = 1'b0; mv = 1'b0; mn = 1'b0;
      @(posedge clk); #1;
      check("rst_red2_valid", 32'(out_valid), 32'd0);
      check("rst_red2_result", 32'(result), 32'd0);
      check("rst_red2_flags", 32'({out_err, flag_z, flag_v, flag_n}), 32'd0);
      check("rst_red2_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      // 32-bit instance.
      op32 = 3'd3; a32 = 32'h01010101; b32 = 32'h01010101; in_valid32 = 1'b1;
      @(negedge clk);
      check("w32_ready", 32'(in_ready32), 32'd1);
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      check("w32_red2", 32'({in_ready32, out_valid32}), 32'd0);
      @(posedge clk); #1;
      check("w32_red_valid", 32'(out_valid32), 32'd1);
      check("w32_red", result32, 32'h00000008);
      in_valid32 = 1'b1; a32 = 32'h7F7F7F7F;
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("w32_rst", 32'({in_ready32, out_valid32, out_err32}), 32'b100);
      check("w32_rst_result", result32, 32'd0);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
